// File: rtl/ddr_port_arbiter.sv
// ddr_port_arbiter
//   Round-robin arbiter that shares one native valid/ready DDR memory port
//   between N_REQ requesters. Only one transaction can be outstanding at a
//   time. The winner's address, write data and strobe are registered onto the
//   mem_* port. Read data is returned only to the winner. A watchdog ends a
//   stalled transaction and sets a sticky error flag.
//
// Ports
//   clk, rst                  clock, asynchronous active-low reset
//   req_valid/addr/wdata/wstrb per-requester requests (flattened, i at [i*W +: W])
//   req_rdata, req_ready      read data and one-hot completion pulse
//   mem_valid/addr/wdata/wstrb registered request to the memory port
//   mem_rdata, mem_ready      memory read data and one-cycle completion
//   grant                     one-hot current owner, zero when idle
//   err_timeout, err_clr      sticky watchdog flag and its clear
//
// state | meaning
// IDLE  | no transaction; arbitrate among req_valid
// BUSY  | mem_valid high, waiting for mem_ready or the watchdog
// DONE  | req_ready pulse cycle; lets the winner drop req_valid

module ddr_port_arbiter #(
    parameter int N_REQ     = 2,
    parameter int ADDR_W    = 30,
    parameter int DATA_W    = 32,
    parameter int TIMEOUT_W = 12
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [N_REQ-1:0]             req_valid,
    input  logic [N_REQ*ADDR_W-1:0]      req_addr,
    input  logic [N_REQ*DATA_W-1:0]      req_wdata,
    input  logic [N_REQ*(DATA_W/8)-1:0]  req_wstrb,
    output logic [DATA_W-1:0]            req_rdata,
    output logic [N_REQ-1:0]             req_ready,
    output logic                         mem_valid,
    output logic [ADDR_W-1:0]            mem_addr,
    output logic [DATA_W-1:0]            mem_wdata,
    output logic [DATA_W/8-1:0]          mem_wstrb,
    input  logic [DATA_W-1:0]            mem_rdata,
    input  logic                         mem_ready,
    output logic [N_REQ-1:0]             grant,
    output logic                         err_timeout,
    input  logic                         err_clr
);

    localparam int STRB_W = DATA_W / 8;
    localparam int IDX_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    // The watchdog fires on the edge where the count would reach all-ones,
    // which is the (2^TIMEOUT_W-1)th edge spent in BUSY.
    localparam logic [TIMEOUT_W-1:0] WD_LAST = {{(TIMEOUT_W-1){1'b1}}, 1'b0};

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

    state_t                 r_state, w_state_nxt;
    logic                   r_mem_valid, w_mem_valid_nxt;
    logic [ADDR_W-1:0]      r_mem_addr, w_mem_addr_nxt;
    logic [DATA_W-1:0]      r_mem_wdata, w_mem_wdata_nxt;
    logic [STRB_W-1:0]      r_mem_wstrb, w_mem_wstrb_nxt;
    logic [DATA_W-1:0]      r_req_rdata, w_req_rdata_nxt;
    logic [N_REQ-1:0]       r_req_ready, w_req_ready_nxt;
    logic [N_REQ-1:0]       r_grant, w_grant_nxt;
    logic                   r_err, w_err_nxt;
    logic [TIMEOUT_W-1:0]   r_wd, w_wd_nxt;
    logic [IDX_W-1:0]       r_last, w_last_nxt;

    logic                   w_found;
    logic [IDX_W-1:0]       w_sel_idx;
    logic [N_REQ-1:0]       w_sel_oh;
    logic [ADDR_W-1:0]      w_sel_addr;
    logic [DATA_W-1:0]      w_sel_wdata;
    logic [STRB_W-1:0]      w_sel_wstrb;
    logic                   w_wd_fire;

    // Search order starts one past the last winner and wraps.
    always_comb begin
        w_found   = 1'b0;
        w_sel_idx = '0;
        w_sel_oh  = '0;
        for (int k = 0; k < N_REQ; k++) begin
            for (int j = 0; j < N_REQ; j++) begin
                if (!w_found && req_valid[j] && (j == (int'(r_last) + k + 1) % N_REQ)) begin
                    w_found     = 1'b1;
                    w_sel_idx   = IDX_W'(j);
                    w_sel_oh[j] = 1'b1;
                end
            end
        end
    end

    always_comb begin
        w_sel_addr  = '0;
        w_sel_wdata = '0;
        w_sel_wstrb = '0;
        for (int j = 0; j < N_REQ; j++) begin
            if (w_sel_oh[j]) begin
                w_sel_addr  = req_addr[j*ADDR_W +: ADDR_W];
                w_sel_wdata = req_wdata[j*DATA_W +: DATA_W];
                w_sel_wstrb = req_wstrb[j*STRB_W +: STRB_W];
            end
        end
    end

    assign w_wd_fire = (r_wd == WD_LAST);

    // State register (also carries all registered outputs)
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_mem_valid <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_mem_wstrb <= '0;
            r_req_rdata <= '0;
            r_req_ready <= '0;
            r_grant     <= '0;
            r_err       <= 1'b0;
            r_wd        <= '0;
            r_last      <= IDX_W'(N_REQ - 1);
        end else begin
            r_state     <= w_state_nxt;
            r_mem_valid <= w_mem_valid_nxt;
            r_mem_addr  <= w_mem_addr_nxt;
            r_mem_wdata <= w_mem_wdata_nxt;
            r_mem_wstrb <= w_mem_wstrb_nxt;
            r_req_rdata <= w_req_rdata_nxt;
            r_req_ready <= w_req_ready_nxt;
            r_grant     <= w_grant_nxt;
            r_err       <= w_err_nxt;
            r_wd        <= w_wd_nxt;
            r_last      <= w_last_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_found) w_state_nxt = S_BUSY;
            S_BUSY:  if (mem_ready || w_wd_fire) w_state_nxt = S_DONE;
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        w_mem_valid_nxt = r_mem_valid;
        w_mem_addr_nxt  = r_mem_addr;
        w_mem_wdata_nxt = r_mem_wdata;
        w_mem_wstrb_nxt = r_mem_wstrb;
        w_req_rdata_nxt = r_req_rdata;
        w_req_ready_nxt = '0;
        w_grant_nxt     = r_grant;
        w_wd_nxt        = r_wd;
        w_last_nxt      = r_last;
        w_err_nxt       = r_err & ~err_clr;
        case (r_state)
            S_IDLE: begin
                if (w_found) begin
                    w_mem_valid_nxt = 1'b1;
                    w_mem_addr_nxt  = w_sel_addr;
                    w_mem_wdata_nxt = w_sel_wdata;
                    w_mem_wstrb_nxt = w_sel_wstrb;
                    w_grant_nxt     = w_sel_oh;
                    w_wd_nxt        = '0;
                    w_last_nxt      = w_sel_idx;
                end
            end
            S_BUSY: begin
                w_wd_nxt = r_wd + 1'b1;
                // A real completion takes precedence over a coincident timeout.
                if (mem_ready) begin
                    w_mem_valid_nxt = 1'b0;
                    w_req_rdata_nxt = mem_rdata;
                    w_req_ready_nxt = r_grant;
                end else if (w_wd_fire) begin
                    w_mem_valid_nxt = 1'b0;
                    w_req_rdata_nxt = '0;
                    w_req_ready_nxt = r_grant;
                    w_err_nxt       = 1'b1;
                end
            end
            S_DONE: begin
                w_grant_nxt = '0;
            end
            default: begin
                w_grant_nxt = '0;
            end
        endcase
    end

    assign mem_valid   = r_mem_valid;
    assign mem_addr    = r_mem_addr;
    assign mem_wdata   = r_mem_wdata;
    assign mem_wstrb   = r_mem_wstrb;
    assign req_rdata   = r_req_rdata;
    assign req_ready   = r_req_ready;
    assign grant       = r_grant;
    assign err_timeout = r_err;

endmodule

// File: tb/tb_ddr_port_arbiter.sv
// tb_ddr_port_arbiter
//   Directed self-checking bench for ddr_port_arbiter with two requesters and
//   a 4-bit watchdog (fires after 15 cycles in BUSY).

module tb_ddr_port_arbiter;

    localparam int N_REQ  = 2;
    localparam int ADDR_W = 30;
    localparam int DATA_W = 32;
    localparam int STRB_W = 4;

    logic                      clk;
    logic                      rst;
    logic [N_REQ-1:0]          req_valid;
    logic [N_REQ*ADDR_W-1:0]   req_addr;
    logic [N_REQ*DATA_W-1:0]   req_wdata;
    logic [N_REQ*STRB_W-1:0]   req_wstrb;
    logic [DATA_W-1:0]         req_rdata;
    logic [N_REQ-1:0]          req_ready;
    logic                      mem_valid;
    logic [ADDR_W-1:0]         mem_addr;
    logic [DATA_W-1:0]         mem_wdata;
    logic [STRB_W-1:0]         mem_wstrb;
    logic [DATA_W-1:0]         mem_rdata;
    logic                      mem_ready;
    logic [N_REQ-1:0]          grant;
    logic                      err_timeout;
    logic                      err_clr;

    int n_checks = 0;
    int n_errors = 0;

    ddr_port_arbiter #(
        .N_REQ(N_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT_W(4)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_wstrb(req_wstrb), .req_rdata(req_rdata), .req_ready(req_ready),
        .mem_valid(mem_valid), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .grant(grant), .err_timeout(err_timeout), .err_clr(err_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int r, input logic v, input logic [ADDR_W-1:0] a,
                           input logic [DATA_W-1:0] d, input logic [STRB_W-1:0] s);
        req_valid[r]                 = v;
        req_addr[r*ADDR_W +: ADDR_W] = a;
        req_wdata[r*DATA_W +: DATA_W] = d;
        req_wstrb[r*STRB_W +: STRB_W] = s;
    endtask

    task automatic do_reset();
        rst       = 1'b0;
        req_valid = '0;
        mem_ready = 1'b0;
        mem_rdata = '0;
        err_clr   = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        rst       = 1'b0;
        req_valid = '0;
        req_addr  = '0;
        req_wdata = '0;
        req_wstrb = '0;
        mem_ready = 1'b0;
        mem_rdata = '0;
        err_clr   = 1'b0;
        tick();
        tick();
        n_checks++; if (mem_valid !== 1'b0) begin n_errors++; $display("FAIL rst_mem_valid: got %b expected 0", mem_valid); end
        n_checks++; if (req_ready !== 2'b00) begin n_errors++; $display("FAIL rst_req_ready: got %b expected 00", req_ready); end
        n_checks++; if (grant !== 2'b00) begin n_errors++; $display("FAIL rst_grant: got %b expected 00", grant); end
        n_checks++; if (err_timeout !== 1'b0) begin n_errors++; $display("FAIL rst_err: got %b expected 0", err_timeout); end
        n_checks++; if ({mem_addr, mem_wdata, mem_wstrb, req_rdata} !== '0) begin
            n_errors++; $display("FAIL rst_data: got addr %h wdata %h wstrb %h rdata %h expected all 0",
                                 mem_addr, mem_wdata, mem_wstrb, req_rdata); end
        rst = 1'b1;
        tick();
    endtask

    task automatic test_single_read();
        int hi;
        do_reset();
        set_req(0, 1'b1, 30'h100, 32'h0, 4'h0);
        tick();
        hi = 1;
        n_checks++; if ({mem_valid, grant} !== 3'b101) begin n_errors++; $display("FAIL rd_start: got valid %b grant %b expected 1 01", mem_valid, grant); end
        n_checks++; if ({mem_addr, mem_wstrb} !== {30'h100, 4'h0}) begin n_errors++; $display("FAIL rd_addr: got %h/%h expected 100/0", mem_addr, mem_wstrb); end
        for (int c = 0; c < 2; c++) begin
            tick();
            if (mem_valid) hi++;
        end
        mem_ready = 1'b1;
        mem_rdata = 32'hDEADBEEF;
        tick();
        mem_ready = 1'b0;
        n_checks++; if (hi !== 3 || mem_valid !== 1'b0) begin n_errors++; $display("FAIL rd_valid_len: got %0d cycles, valid now %b, expected 3 and 0", hi, mem_valid); end
        n_checks++; if (req_ready !== 2'b01) begin n_errors++; $display("FAIL rd_ready: got %b expected 01", req_ready); end
        n_checks++; if (req_rdata !== 32'hDEADBEEF) begin n_errors++; $display("FAIL rd_data: got %h expected deadbeef", req_rdata); end
        n_checks++; if (grant !== 2'b01) begin n_errors++; $display("FAIL rd_grant_done: got %b expected 01", grant); end
        req_valid[0] = 1'b0;
        tick();
        n_checks++; if ({req_ready, grant} !== 4'b0000) begin n_errors++; $display("FAIL rd_after: got ready %b grant %b expected 00 00", req_ready, grant); end
    endtask

    task automatic test_simultaneous();
        do_reset();
        set_req(0, 1'b1, 30'h010, 32'h0, 4'h0);
        set_req(1, 1'b1, 30'h020, 32'h0, 4'h0);
        tick();
        n_checks++; if ({mem_valid, grant, mem_addr} !== {1'b1, 2'b01, 30'h010}) begin n_errors++; $display("FAIL sim_first: got valid %b grant %b addr %h expected 1 01 010", mem_valid, grant, mem_addr); end
        mem_ready = 1'b1;
        mem_rdata = 32'h11111111;
        tick();
        mem_ready = 1'b0;
        req_valid[0] = 1'b0;
        n_checks++; if (req_ready !== 2'b01) begin n_errors++; $display("FAIL sim_ready0: got %b expected 01", req_ready); end
        tick();
        n_checks++; if (mem_valid !== 1'b0) begin n_errors++; $display("FAIL sim_gap: got valid %b expected 0", mem_valid); end
        tick();
        n_checks++; if ({mem_valid, grant, mem_addr} !== {1'b1, 2'b10, 30'h020}) begin n_errors++; $display("FAIL sim_second: got valid %b grant %b addr %h expected 1 10 020", mem_valid, grant, mem_addr); end
        mem_ready = 1'b1;
        mem_rdata = 32'h22222222;
        tick();
        mem_ready = 1'b0;
        req_valid[1] = 1'b0;
        n_checks++; if ({req_ready, req_rdata} !== {2'b10, 32'h22222222}) begin n_errors++; $display("FAIL sim_ready1: got %b %h expected 10 22222222", req_ready, req_rdata); end
        tick();
    endtask

    task automatic test_contention();
        logic [1:0]  exp_g;
        logic [29:0] exp_a;
        do_reset();
        set_req(0, 1'b1, 30'h0AA0, 32'h0, 4'h0);
        set_req(1, 1'b1, 30'h0BB0, 32'h0, 4'h0);
        for (int t = 0; t < 8; t++) begin
            int n;
            n = 0;
            while (mem_valid !== 1'b1 && n < 10) begin
                tick();
                n++;
            end
            exp_g = (t % 2 == 0) ? 2'b01 : 2'b10;
            exp_a = (t % 2 == 0) ? 30'h0AA0 : 30'h0BB0;
            n_checks++; if (n >= 10) begin n_errors++; $display("FAIL cont_wait%0d: mem_valid not seen within 10 cycles", t); end
            n_checks++; if ({grant, mem_addr} !== {exp_g, exp_a}) begin n_errors++; $display("FAIL cont_grant%0d: got %b addr %h expected %b addr %h", t, grant, mem_addr, exp_g, exp_a); end
            mem_ready = 1'b1;
            mem_rdata = 32'hA0000000 + 32'(t);
            tick();
            mem_ready = 1'b0;
            n_checks++; if ({req_ready, req_rdata} !== {exp_g, 32'hA0000000 + 32'(t)}) begin n_errors++; $display("FAIL cont_ready%0d: got %b %h expected %b %h", t, req_ready, req_rdata, exp_g, 32'hA0000000 + 32'(t)); end
        end
        req_valid = '0;
        tick();
        tick();
    endtask

    task automatic test_write();
        int pulses;
        do_reset();
        set_req(1, 1'b1, 30'h2A0, 32'h12345678, 4'b0011);
        set_req(0, 1'b0, 30'h3FF, 32'hFFFFFFFF, 4'hF);
        tick();
        n_checks++; if (grant !== 2'b10) begin n_errors++; $display("FAIL wr_grant: got %b expected 10", grant); end
        for (int c = 0; c < 4; c++) begin
            n_checks++; if ({mem_valid, mem_addr, mem_wdata, mem_wstrb} !== {1'b1, 30'h2A0, 32'h12345678, 4'b0011}) begin
                n_errors++; $display("FAIL wr_hold%0d: got %b %h %h %b expected 1 2a0 12345678 0011", c, mem_valid, mem_addr, mem_wdata, mem_wstrb); end
            set_req(0, 1'b0, 30'(c), 32'(c), 4'(c));
            tick();
        end
        mem_ready = 1'b1;
        tick();
        mem_ready = 1'b0;
        req_valid[1] = 1'b0;
        pulses = (req_ready == 2'b10) ? 1 : 0;
        n_checks++; if (req_ready !== 2'b10) begin n_errors++; $display("FAIL wr_ready: got %b expected 10", req_ready); end
        for (int c = 0; c < 3; c++) begin
            tick();
            if (req_ready != 2'b00) pulses++;
        end
        n_checks++; if (pulses !== 1) begin n_errors++; $display("FAIL wr_pulses: got %0d expected 1", pulses); end
    endtask

    task automatic test_watchdog();
        int hi;
        do_reset();
        set_req(0, 1'b1, 30'h040, 32'h0, 4'h0);
        tick();
        mem_ready = 1'b1;
        mem_rdata = 32'hCAFEF00D;
        tick();
        mem_ready = 1'b0;
        req_valid[0] = 1'b0;
        set_req(1, 1'b1, 30'h044, 32'h0, 4'h0);
        tick();
        tick();
        n_checks++; if ({mem_valid, grant, req_rdata} !== {1'b1, 2'b10, 32'hCAFEF00D}) begin n_errors++; $display("FAIL wd_start: got %b %b %h expected 1 10 cafef00d", mem_valid, grant, req_rdata); end
        hi = 1;
        for (int c = 0; c < 20; c++) begin
            tick();
            if (mem_valid) hi++;
            else break;
        end
        n_checks++; if (hi !== 15) begin n_errors++; $display("FAIL wd_cycles: got %0d expected 15", hi); end
        n_checks++; if ({req_ready, req_rdata} !== {2'b10, 32'h0}) begin n_errors++; $display("FAIL wd_ready: got %b %h expected 10 00000000", req_ready, req_rdata); end
        n_checks++; if (err_timeout !== 1'b1) begin n_errors++; $display("FAIL wd_err_set: got %b expected 1", err_timeout); end
        req_valid[1] = 1'b0;
        for (int c = 0; c < 4; c++) tick();
        n_checks++; if ({err_timeout, req_ready} !== 3'b100) begin n_errors++; $display("FAIL wd_err_sticky: got err %b ready %b expected 1 00", err_timeout, req_ready); end
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        n_checks++; if (err_timeout !== 1'b0) begin n_errors++; $display("FAIL wd_err_clr: got %b expected 0", err_timeout); end

        // mem_ready on the very edge the watchdog would fire: normal completion
        set_req(0, 1'b1, 30'h048, 32'h0, 4'h0);
        tick();
        for (int c = 0; c < 14; c++) tick();
        n_checks++; if ({mem_valid, grant} !== 3'b101) begin n_errors++; $display("FAIL wd_edge_busy: got %b %b expected 1 01", mem_valid, grant); end
        mem_ready = 1'b1;
        mem_rdata = 32'h5A5A5A5A;
        tick();
        mem_ready = 1'b0;
        req_valid[0] = 1'b0;
        n_checks++; if ({req_ready, req_rdata, err_timeout} !== {2'b01, 32'h5A5A5A5A, 1'b0}) begin n_errors++; $display("FAIL wd_edge_done: got %b %h err %b expected 01 5a5a5a5a 0", req_ready, req_rdata, err_timeout); end
        tick();

        // err_clr held while a timeout occurs: set wins, then clear takes effect
        err_clr = 1'b1;
        set_req(1, 1'b1, 30'h04C, 32'h0, 4'h0);
        tick();
        hi = 1;
        for (int c = 0; c < 20; c++) begin
            tick();
            if (mem_valid) hi++;
            else break;
        end
        n_checks++; if ({hi == 15, err_timeout, req_ready} !== 4'b1110) begin n_errors++; $display("FAIL wd_set_wins: got cycles %0d err %b ready %b expected 15 1 10", hi, err_timeout, req_ready); end
        req_valid[1] = 1'b0;
        tick();
        n_checks++; if (err_timeout !== 1'b0) begin n_errors++; $display("FAIL wd_clr_after: got %b expected 0", err_timeout); end
        err_clr = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid();
        do_reset();
        set_req(0, 1'b1, 30'h0C0, 32'h0, 4'h0);
        set_req(1, 1'b1, 30'h0D0, 32'h0, 4'h0);
        tick();
        n_checks++; if ({mem_valid, grant} !== 3'b101) begin n_errors++; $display("FAIL rm_busy: got %b %b expected 1 01", mem_valid, grant); end
        tick();
        #3;
        rst = 1'b0;
        #1;
        n_checks++; if ({mem_valid, grant, req_ready} !== 5'b00000) begin n_errors++; $display("FAIL rm_async: got valid %b grant %b ready %b expected 0 00 00", mem_valid, grant, req_ready); end
        req_valid = '0;
        tick();
        rst = 1'b1;
        mem_ready = 1'b1;
        mem_rdata = 32'h0BADBAD0;
        tick();
        mem_ready = 1'b0;
        n_checks++; if ({req_ready, mem_valid, req_rdata} !== {2'b00, 1'b0, 32'h0}) begin n_errors++; $display("FAIL rm_late_ready: got ready %b valid %b rdata %h expected 00 0 0", req_ready, mem_valid, req_rdata); end
        tick();
        n_checks++; if (req_ready !== 2'b00) begin n_errors++; $display("FAIL rm_no_pulse: got %b expected 00", req_ready); end
        req_valid = 2'b11;
        tick();
        n_checks++; if ({mem_valid, grant, mem_addr} !== {1'b1, 2'b01, 30'h0C0}) begin n_errors++; $display("FAIL rm_regrant: got %b %b %h expected 1 01 0c0", mem_valid, grant, mem_addr); end
        mem_ready = 1'b1;
        tick();
        mem_ready = 1'b0;
        req_valid = '0;
        tick();
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_simultaneous();
        test_contention();
        test_write();
        test_watchdog();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
